// File: rtl/keyscan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states,
// the {row,col} key map and the lowest-low-row encoder.
package keyscan_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEB_PRESS,
        HELD,
        DEB_REL
    } state_t;

    // Packed so that KEYMAP[{row,col}] selects the code; index 15 (r3c3) is leftmost.
    localparam logic [15:0][3:0] KEYMAP = {
        4'hD, 4'hF, 4'h0, 4'hE,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [1:0] onehot_low_to_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous active-low keypad rows.
// Reset presets both stages to "no key" (all ones).
module keypad_row_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] srows
);

    logic [3:0] meta_q, meta_d;
    logic [3:0] sync_q, sync_d;

    always_comb begin
        meta_d = rows;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign srows = sync_q;

endmodule

// File: rtl/keypad_scan_digits.sv
// 4x4 keypad scanner with press/release debounce feeding a two-digit key history.
// Define KEYSCAN_AUTOREPEAT_EN to re-shift the held key every REPEAT_CYCLES cycles.
module keypad_scan_digits
    import keyscan_pkg::*;
#(
    parameter int SCAN_DIV        = 4096,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int REPEAT_CYCLES   = 4000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] hexL,
    output logic [3:0] hexR,
    output logic       key_valid
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_ONE  = 1;
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE   = 1;

    logic [3:0] srows;

    keypad_row_sync u_row_sync (
        .clk   (clk),
        .reset (reset),
        .rows  (rows),
        .srows (srows)
    );

    state_t             state_q, state_d;
    logic [1:0]         col_q, col_d;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic [3:0]         pattern_q, pattern_d;
    logic [3:0]         code_q, code_d;
    logic [3:0]         hex_l_q, hex_l_d;
    logic [3:0]         hex_r_q, hex_r_d;
    logic               key_valid_q, key_valid_d;
    logic               do_shift;
    logic [3:0]         key_idx;

`ifdef KEYSCAN_AUTOREPEAT_EN
    localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_ONE  = 1;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        scan_cnt_d  = scan_cnt_q;
        deb_cnt_d   = deb_cnt_q;
        pattern_d   = pattern_q;
        code_d      = code_q;
        hex_l_d     = hex_l_q;
        hex_r_d     = hex_r_q;
        key_valid_d = 1'b0;
        do_shift    = 1'b0;
        key_idx     = {onehot_low_to_idx(srows), col_q};
`ifdef KEYSCAN_AUTOREPEAT_EN
        // Only an uninterrupted stay in HELD keeps the repeat count alive.
        rep_cnt_d   = '0;
`endif

        case (state_q)
            SCAN: begin
                if (scan_cnt_q != SCAN_LAST) begin
                    scan_cnt_d = scan_cnt_q + SCAN_ONE;
                end else if (srows == 4'hF) begin
                    col_d      = col_q + 2'd1;
                    scan_cnt_d = '0;
                end else begin
                    pattern_d  = srows;
                    code_d     = KEYMAP[key_idx];
                    deb_cnt_d  = '0;
                    scan_cnt_d = '0;
                    state_d    = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (srows != pattern_q) begin
                    col_d      = col_q + 2'd1;
                    scan_cnt_d = '0;
                    state_d    = SCAN;
                end else if (deb_cnt_q == DEB_LAST) begin
                    do_shift = 1'b1;
                    state_d  = HELD;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_ONE;
                end
            end
            HELD: begin
                if (srows == 4'hF) begin
                    deb_cnt_d = '0;
                    state_d   = DEB_REL;
                end
`ifdef KEYSCAN_AUTOREPEAT_EN
                else if (rep_cnt_q == REP_LAST) begin
                    do_shift = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_ONE;
                end
`endif
            end
            DEB_REL: begin
                if (srows != 4'hF) begin
                    deb_cnt_d = '0;
                    state_d   = HELD;
                end else if (deb_cnt_q == DEB_LAST) begin
                    col_d      = col_q + 2'd1;
                    scan_cnt_d = '0;
                    state_d    = SCAN;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_ONE;
                end
            end
            default: state_d = SCAN;
        endcase

        if (do_shift) begin
            hex_l_d     = hex_r_q;
            hex_r_d     = code_q;
            key_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= SCAN;
            col_q       <= 2'd0;
            scan_cnt_q  <= '0;
            deb_cnt_q   <= '0;
            pattern_q   <= 4'hF;
            code_q      <= 4'h0;
            hex_l_q     <= 4'h0;
            hex_r_q     <= 4'h0;
            key_valid_q <= 1'b0;
`ifdef KEYSCAN_AUTOREPEAT_EN
            rep_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            scan_cnt_q  <= scan_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            pattern_q   <= pattern_d;
            code_q      <= code_d;
            hex_l_q     <= hex_l_d;
            hex_r_q     <= hex_r_d;
            key_valid_q <= key_valid_d;
`ifdef KEYSCAN_AUTOREPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
`endif
        end
    end

    assign cols      = ~(4'b0001 << col_q);
    assign hexL      = hex_l_q;
    assign hexR      = hex_r_q;
    assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scan_digits.sv
// Directed bench for keypad_scan_digits with a behavioural 4x4 keypad model
// (SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=32).
module tb_keypad_scan_digits;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] hexL;
    logic [3:0] hexR;
    logic       key_valid;

    logic [15:0] pressed = 16'h0000;   // bit r*4+c = key at row r, column c held down

    int checks = 0;
    int errors = 0;

    keypad_scan_digits #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8),
        .REPEAT_CYCLES   (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .hexL      (hexL),
        .hexR      (hexR),
        .key_valid (key_valid)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its row to its column only while that column is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        $display("check %s got=%0h exp=%0h", tag, got, exp);
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of cycles until key_valid is seen, or 0 if the budget expires.
    task automatic wait_kv(input int budget, output int n);
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (key_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_cols(input logic [3:0] want, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cols == want) begin
                found = 1'b1;
                break;
            end
            step();
        end
    endtask

    initial begin
        int  n;
        int  pulses;
        bit  found;
        logic [3:0] exp_cols;

        // Reset and idle scan
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("reset_hexL", 32'(hexL), 32'h0);
        chk("reset_hexR", 32'(hexR), 32'h0);
        chk("reset_kv", 32'(key_valid), 32'h0);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            exp_cols = ~(4'b0001 << (i / 4));
            chk($sformatf("idle_cols_%0d", i), 32'(cols), 32'(exp_cols));
            if (key_valid) pulses++;
            step();
        end
        chk("idle_no_kv", 32'(pulses), 32'd0);
        chk("idle_hexR", 32'(hexR), 32'h0);

        // Key 6 (r1c2): one pulse, hexR=6 hexL=0
        pressed = 16'h0040;
        wait_kv(60, n);
        chk("k6_seen", 32'(n != 0), 32'd1);
        chk("k6_hexR", 32'(hexR), 32'h6);
        chk("k6_hexL", 32'(hexL), 32'h0);
        step();
        chk("k6_pulse_width", 32'(key_valid), 32'h0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (key_valid) pulses++;
        end
        chk("k6_single_pulse", 32'(pulses), 32'd0);
        pressed = 16'h0000;
        repeat (16) step();

        // Key 0 (r3c1): history shifts
        pressed = 16'h2000;
        wait_kv(60, n);
        chk("k0_seen", 32'(n != 0), 32'd1);
        chk("k0_hexR", 32'(hexR), 32'h0);
        chk("k0_hexL", 32'(hexL), 32'h6);
        pressed = 16'h0000;
        repeat (16) step();

        // Key A (r0c3) glitch shorter than the debounce window
        wait_cols(4'b0111, 40, found);
        chk("glitch_col_found", 32'(found), 32'd1);
        pressed = 16'h0008;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (i == 5) pressed = 16'h0000;
            if (key_valid) pulses++;
        end
        chk("glitch_no_kv", 32'(pulses), 32'd0);
        chk("glitch_hexR", 32'(hexR), 32'h0);
        chk("glitch_hexL", 32'(hexL), 32'h6);

        // Hold key 5 (r1c1), press key 9 (r2c2) meanwhile: no rollover
        pressed = 16'h0020;
        wait_kv(60, n);
        chk("k5_seen", 32'(n != 0), 32'd1);
        chk("k5_hexR", 32'(hexR), 32'h5);
        chk("k5_hexL", 32'(hexL), 32'h0);
        pressed = 16'h0420;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (key_valid) pulses++;
        end
        chk("k9_ignored_while_held", 32'(pulses), 32'd0);
        chk("k5_still_hexR", 32'(hexR), 32'h5);
        pressed = 16'h0400;
        wait_kv(60, n);
        chk("k9_seen", 32'(n != 0), 32'd1);
        chk("k9_hexR", 32'(hexR), 32'h9);
        chk("k9_hexL", 32'(hexL), 32'h5);
        pressed = 16'h0000;
        repeat (16) step();

        // Reset during DEB_PRESS on key 1 (r0c0)
        wait_cols(4'b1110, 40, found);
        chk("rst_col_found", 32'(found), 32'd1);
        pressed = 16'h0001;
        repeat (6) step();
        reset   = 1'b0;
        pressed = 16'h0000;
        step();
        reset = 1'b1;
        chk("rst_cols", 32'(cols), 32'he);
        chk("rst_hexR", 32'(hexR), 32'h0);
        chk("rst_hexL", 32'(hexL), 32'h0);
        chk("rst_kv", 32'(key_valid), 32'h0);
        repeat (4) step();
        chk("rst_scan_resumed", 32'(cols), 32'hd);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (key_valid) pulses++;
        end
        chk("rst_pending_discarded", 32'(pulses), 32'd0);

`ifdef KEYSCAN_AUTOREPEAT_EN
        // Hold key A: accept, then repeat every 32 cycles
        pressed = 16'h0008;
        wait_kv(60, n);
        chk("rep_first_seen", 32'(n != 0), 32'd1);
        chk("rep_first_hexR", 32'(hexR), 32'hA);
        wait_kv(40, n);
        chk("rep_interval", 32'(n), 32'd32);
        chk("rep_hexR", 32'(hexR), 32'hA);
        chk("rep_hexL", 32'(hexL), 32'hA);
        pressed = 16'h0000;
        repeat (16) step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scan_digits.md
Name: keypad_scan_digits

Overview:
- Upstream feeder of the two-digit display multiplexer.
- Scans a 4x4 matrix keypad by driving columns low one at a time and reading the active-low rows through a synchronizer.
- Debounces press and release.
- Shifts each accepted key code into a two-digit history: hexL = previous key, hexR = newest key. The display mux consumes both digits directly.

Parameters:
- SCAN_DIV, 4096, clk cycles each column is driven before advancing.
- DEBOUNCE_CYCLES, 65536, consecutive stable synchronized-row cycles required to accept a press or a release.
- REPEAT_CYCLES, 4000000, auto-repeat interval. Used only with KEYSCAN_AUTOREPEAT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk)
- rows  in  4  keypad row lines, asynchronous, active-low (pulled up externally)
- cols  out  4  keypad column drive, active-low, one-cold
- hexL  out  4  older key code, to display mux left digit
- hexR  out  4  newest key code, to display mux right digit
- key_valid  out  1  one-cycle pulse, coincident with the cycle the new hexL/hexR first appear

Behaviour:
- Reset (reset==0 at posedge) gives:
  - cols=4'b1110, col index 0, state SCAN
  - hexL=hexR=4'h0, key_valid=0
  - all counters 0, synchronizer flops 4'b1111
- Reset mid-debounce or mid-hold discards the pending key. No shift occurs.
- Rows pass through 2-flop synchronizer; "srows" denotes its output. All decisions use srows only.
- Key map (row r, col c):
  - r0 = 1 2 3 A
  - r1 = 4 5 6 B
  - r2 = 7 8 9 C
  - r3 = E 0 F D
- States:
  - SCAN:
    - Column counter counts 0..SCAN_DIV-1. srows is sampled only at count SCAN_DIV-1, which allows settling plus 2 sync cycles.
    - If all srows are high: advance column (3 wraps to 0), cols = ~(1<<idx).
    - If any srow is low: latch row = lowest-index low row, plus the current col. Go to DEB_PRESS and hold the column.
  - DEB_PRESS:
    - Count cycles while srows equals the latched pattern.
    - Any mismatch: back to SCAN, advance column, no output.
    - Count reaches DEBOUNCE_CYCLES-1: next cycle hexL<=hexR, hexR<=code, key_valid=1. Go to HELD.
  - HELD:
    - Column stays driven; other keys are ignored (no rollover).
    - When srows==4'b1111, go to DEB_REL with counter cleared.
  - DEB_REL:
    - Count consecutive all-high srows cycles.
    - Any low srow: back to HELD.
    - Count reaches DEBOUNCE_CYCLES-1: go to SCAN, advance column.
- Simultaneous presses in one column: lowest row wins. Multi-column presses: first column reached wins.
- key_valid is high exactly one cycle per accepted press. hexL/hexR are registered and change only on that cycle.
- Counter width is $clog2 of the parameter, minimum 1. Counters saturate, never wrap, inside a state.
- Worst-case press latency: 2 + 4*SCAN_DIV + DEBOUNCE_CYCLES + 1 cycles.

Optional Feature:
- Macro: KEYSCAN_AUTOREPEAT_EN.
- Defined:
  - In HELD, a repeat counter runs.
  - Every REPEAT_CYCLES cycles the held code is shifted in again, with a one-cycle key_valid pulse.
  - The counter clears on entering HELD and on leaving it.
- Undefined:
  - No repeat logic or counter is synthesized.
  - HELD produces no further outputs.

Decomposition:
- Package keyscan_pkg:
  - state typedef enum {SCAN, DEB_PRESS, HELD, DEB_REL}
  - KEYMAP constant (16x4-bit, indexed {row,col})
  - function onehot_low_to_idx
- Sub-module keypad_row_sync:
  - 4-bit 2-flop synchronizer with the same synchronous active-low reset, preset to 4'b1111.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=32):
- Reset, idle rows=4'hF:
  - cols cycles 1110, 1101, 1011, 0111, changing every 4 cycles.
  - hexL=hexR=0, key_valid never 1.
- Press r1c2 (rows[1] low only while cols==1011), held stable, then released:
  - One key_valid pulse; hexR=6, hexL=0.
  - Then press r3c1: hexR=0, hexL=6.
- Press r0c3 with a 3-cycle glitch (release after 3 stable cycles):
  - Return to SCAN, no key_valid, digits unchanged.
- Hold key 5 indefinitely; press key 9 while 5 is held:
  - Single pulse, hexR=5 only.
  - After release of 5 for 8 cycles, key 9 is accepted.
- Reset driven 0 for one cycle during DEB_PRESS:
  - Digits stay 0, cols=1110, state SCAN next cycle.
- KEYSCAN_AUTOREPEAT_EN defined, hold key A:
  - key_valid at accept, then every 32 cycles.
  - hexL=hexR=A after the second pulse.
